nfa_chain_engine: RTL and testbench

- Parametrised successor to the per-rule, hand-instantiated NFA engines in the payload engine.
- Implements one linear PCRE chain as a register-per-state NFA. Each state has a compile-time character-class select, an optional self-loop (for `x*` / `\s*`) and an optional bypass (for `x?` / `x*`).
- Consumes the shared one-hot character-class bus and reports per-packet match, first-match byte offset and match count through a valid/ready result port.

---
 rtl/payload_engine_pkg.sv | 29 ++
 rtl/nfa_state_cell.sv | 33 +++
 rtl/nfa_chain_engine.sv | 134 +++++++++++++
 tb/tb_nfa_chain_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/payload_engine_pkg.sv
// Shared payload-engine definitions: class index width, default class
// indices and a helper for building per-state class select vectors.
package payload_engine_pkg;

  localparam int CLS_W      = 6;
  localparam int MAX_STATES = 64;

  typedef logic [CLS_W-1:0] cls_idx_t;

  // Default class indices on the shared one-hot class bus.
  localparam cls_idx_t CLS_SPACE_WS = 6'd60;
  localparam cls_idx_t CLS_DIGIT    = 6'd61;
  localparam cls_idx_t CLS_ALPHA    = 6'd62;
  localparam cls_idx_t CLS_DOT      = 6'd63;

  // Packs the first n class indices into a CLASS_SEL vector (state 0 in the LSBs).
  function automatic logic [MAX_STATES*CLS_W-1:0] cls_sel_pack(
    input cls_idx_t idx [MAX_STATES],
    input int       n
  );
    logic [MAX_STATES*CLS_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_STATES; i++) begin
      if (i < n) v[i*CLS_W +: CLS_W] = idx[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/nfa_state_cell.sv
// One NFA chain state: class gate, optional self-loop, optional bypass
// of the enter term to the next state.
module nfa_state_cell #(
  parameter int NUM_CLASSES = 64,
  parameter int CLS_IDX     = 0,
  parameter bit LOOP        = 1'b0,
  parameter bit SKIP        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_sod,
  input  logic [NUM_CLASSES-1:0] i_cls,
  input  logic                   i_enter,
  output logic                   o_enter_nxt,
  output logic                   o_act_d
);

  logic r_act;
  logic w_act_old;

  // A packet start wipes the old activity before this byte is evaluated.
  assign w_act_old   = r_act & ~i_sod;
  assign o_enter_nxt = w_act_old | (SKIP & i_enter);
  assign o_act_d     = i_cls[CLS_IDX] & (i_enter | (LOOP & w_act_old));

  // State register advances only on valid bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_act <= 1'b0;
    else if (i_en) r_act <= o_act_d;
  end

endmodule

// File: rtl/nfa_chain_engine.sv
// Linear PCRE chain as a register-per-state NFA with per-packet
// match / first-offset / count reporting over a valid/ready port.
module nfa_chain_engine #(
  parameter int                          NUM_STATES  = 28,
  parameter int                          NUM_CLASSES = 64,
  parameter int                          CLS_W       = payload_engine_pkg::CLS_W,
  parameter logic [NUM_STATES*CLS_W-1:0] CLASS_SEL   = '0,
  parameter logic [NUM_STATES-1:0]       LOOP_MASK   = '0,
  parameter logic [NUM_STATES-1:0]       SKIP_MASK   = '0,
  parameter int                          OFF_W       = 16,
  parameter int                          CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sod,
  input  logic                   eod,
  input  logic                   en,
  input  logic [NUM_CLASSES-1:0] cls_in,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_match,
  output logic [OFF_W-1:0]       result_offset,
  output logic [CNT_W-1:0]       result_count,
  output logic                   result_ovf,
  output logic                   match_live
);

  if (NUM_STATES < 2 || NUM_STATES > 64) begin : g_bad_num_states
    $error("nfa_chain_engine: NUM_STATES must be within 2..64");
  end
  if (SKIP_MASK[NUM_STATES-1]) begin : g_bad_skip
    $error("nfa_chain_engine: the final state cannot be optional");
  end

  logic [NUM_STATES:0]   w_enter;
  logic [NUM_STATES-1:0] w_act_d;
  logic                  w_sod;
  logic                  w_eod;
  logic                  w_hit;
  logic                  w_unused_tail;

  assign w_sod      = en & sod;
  assign w_eod      = en & eod;
  assign w_enter[0] = 1'b1;

  for (genvar i = 0; i < NUM_STATES; i++) begin : g_state
    if (int'(CLASS_SEL[i*CLS_W +: CLS_W]) >= NUM_CLASSES) begin : g_bad_sel
      $error("nfa_chain_engine: class select out of range for a state");
    end
    nfa_state_cell #(
      .NUM_CLASSES (NUM_CLASSES),
      .CLS_IDX     (int'(CLASS_SEL[i*CLS_W +: CLS_W])),
      .LOOP        (LOOP_MASK[i]),
      .SKIP        (SKIP_MASK[i])
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (en),
      .i_sod       (w_sod),
      .i_cls       (cls_in),
      .i_enter     (w_enter[i]),
      .o_enter_nxt (w_enter[i+1]),
      .o_act_d     (w_act_d[i])
    );
  end

  // Only the final state's next value reports a hit; the rest of the chain
  // outputs are internal to the enter propagation.
  assign w_unused_tail = ^{w_act_d[NUM_STATES-2:0], w_enter[NUM_STATES]};
  assign w_hit         = en & w_act_d[NUM_STATES-1];

  logic [OFF_W-1:0] r_off;
  logic [OFF_W-1:0] r_first;
  logic [CNT_W-1:0] r_cnt;
  logic             r_live;
  logic [OFF_W-1:0] w_off_cur;
  logic [OFF_W-1:0] w_off_nxt;
  logic [OFF_W-1:0] w_first_cur;
  logic [OFF_W-1:0] w_first_nxt;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_live_cur;
  logic             w_live_nxt;

  // Packet-start bytes see a freshly cleared packet context.
  assign w_off_cur   = w_sod ? '0 : r_off;
  assign w_first_cur = w_sod ? '0 : r_first;
  assign w_cnt_cur   = w_sod ? '0 : r_cnt;
  assign w_live_cur  = w_sod ? 1'b0 : r_live;

  assign w_off_nxt   = (&w_off_cur) ? w_off_cur : w_off_cur + OFF_W'(1);
  assign w_cnt_nxt   = (w_hit && !(&w_cnt_cur)) ? w_cnt_cur + CNT_W'(1) : w_cnt_cur;
  assign w_live_nxt  = w_live_cur | w_hit;
  assign w_first_nxt = (w_hit && !w_live_cur) ? w_off_cur : w_first_cur;

  // Per-packet offset, first-match offset, hit count and live flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off   <= '0;
      r_first <= '0;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else if (en) begin
      r_off   <= w_off_nxt;
      r_first <= w_first_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= w_live_nxt;
    end
  end

  // Result capture at end of packet plus valid/ready handshake; a capture
  // always wins over a same-cycle acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid  <= 1'b0;
      result_match  <= 1'b0;
      result_offset <= '0;
      result_count  <= '0;
      result_ovf    <= 1'b0;
    end else if (w_eod) begin
      result_valid  <= 1'b1;
      result_match  <= w_live_nxt;
      result_offset <= w_first_nxt;
      result_count  <= w_cnt_nxt;
      result_ovf    <= result_valid & ~result_ready;
    end else if (result_valid && result_ready) begin
      result_valid  <= 1'b0;
      result_ovf    <= 1'b0;
    end
  end

  assign match_live = r_live;

endmodule

// File: tb/tb_nfa_chain_engine.sv
// Bench for nfa_chain_engine configured as chain "a b? c* d".
module tb_nfa_chain_engine;
  import payload_engine_pkg::*;

  localparam int NS  = 4;
  localparam int NC  = 64;
  localparam int OW  = 16;
  localparam int CW  = 8;

  logic          clk;
  logic          rst_n;
  logic          sod, eod, en;
  logic [NC-1:0] cls_in;
  logic          result_valid, result_ready, result_match, result_ovf, match_live;
  logic [OW-1:0] result_offset;
  logic [CW-1:0] result_count;

  nfa_chain_engine #(
    .NUM_STATES  (NS),
    .NUM_CLASSES (NC),
    .CLS_W       (CLS_W),
    .CLASS_SEL   ({6'd4, 6'd3, 6'd2, 6'd1}),
    .LOOP_MASK   (4'b0100),
    .SKIP_MASK   (4'b0110),
    .OFF_W       (OW),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sod           (sod),
    .eod           (eod),
    .en            (en),
    .cls_in        (cls_in),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_match  (result_match),
    .result_offset (result_offset),
    .result_count  (result_count),
    .result_ovf    (result_ovf),
    .match_live    (match_live)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string pkt;
    bit    m;
    int    off;
    int    cnt;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int sym_of(input byte c);
    case (c)
      "a": return 1;
      "b": return 2;
      "c": return 3;
      "d": return 4;
      default: return 0;
    endcase
  endfunction

  // One clock with the given byte; inputs return to idle afterwards.
  task automatic drive(input int sym, input bit s, input bit e, input bit v);
    en     = v;
    sod    = s;
    eod    = e;
    cls_in = '0;
    cls_in[sym] = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0; sod = 1'b0; eod = 1'b0; cls_in = '0;
  endtask

  // Garbage on the inputs while en=0 must be ignored.
  task automatic idle();
    drive(4, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_pkt(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      drive(sym_of(s[i]), i == 0, i == s.len() - 1, 1'b1);
      if (i < s.len() - 1) for (int g = 0; g < gap; g++) idle();
    end
  endtask

  task automatic check_result(input string nm, input bit m, input int off, input int cnt, input bit ovf);
    int w;
    w = 0;
    while (!result_valid && w < 4) begin
      @(posedge clk); #1; w++;
    end
    check({nm, " valid"}, 64'(result_valid), 64'd1);
    check({nm, " fields"}, {result_match, result_offset, result_count, result_ovf},
          {m, OW'(off), CW'(cnt), ovf});
  endtask

  task automatic accept(input string nm);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({nm, " valid drop"}, 64'(result_valid), 64'd0);
  endtask

  // Reference: a hit at byte j means some segment k..j spells a b? c* d.
  function automatic bit seg_match(input int q[$], input int k, input int j);
    int p;
    if (q[k] != 1) return 1'b0;
    p = k + 1;
    if (p < j && q[p] == 2) p++;
    while (p < j && q[p] == 3) p++;
    return (p == j) && (q[j] == 4);
  endfunction

  function automatic void ref_pkt(input int q[$], output bit m, output int off, output int cnt);
    m = 1'b0; off = 0; cnt = 0;
    for (int j = 0; j < q.size(); j++) begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k <= j; k++) if (seg_match(q, k, j)) hit = 1'b1;
      if (hit) begin
        cnt++;
        if (!m) begin m = 1'b1; off = j; end
      end
    end
  endfunction

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"xabccd", 1'b1, 5, 1};
    vecs[1] = '{"ad",     1'b1, 1, 1};
    vecs[2] = '{"acccd",  1'b1, 4, 1};
    vecs[3] = '{"abxd",   1'b0, 0, 0};
    vecs[4] = '{"abd",    1'b1, 2, 1};
    vecs[5] = '{"adad",   1'b1, 1, 2};
    vecs[6] = '{"d",      1'b0, 0, 0};
    vecs[7] = '{"aacd",   1'b1, 3, 1};

    rst_n = 1'b0; sod = 1'b0; eod = 1'b0; en = 1'b0; cls_in = '0; result_ready = 1'b0;
    #3;
    check("reset outputs", {result_valid, result_match, result_offset, result_count, result_ovf, match_live}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table of single packets, each accepted before the next.
    for (int v = 0; v < 8; v++) begin
      send_pkt(vecs[v].pkt, 0);
      check_result(vecs[v].pkt, vecs[v].m, vecs[v].off, vecs[v].cnt, 1'b0);
      accept(vecs[v].pkt);
    end

    // match_live: visible after completing byte, cleared at next sod.
    send_pkt("ad", 0);
    check("live after ad", 64'(match_live), 64'd1);
    check_result("ad seq", 1'b1, 1, 1, 1'b0);
    accept("ad seq");
    drive(1, 1'b1, 1'b0, 1'b1);
    check("live cleared at sod", 64'(match_live), 64'd0);
    drive(3, 1'b0, 1'b0, 1'b1);
    drive(3, 1'b0, 1'b0, 1'b1);
    drive(3, 1'b0, 1'b0, 1'b1);
    drive(4, 1'b0, 1'b1, 1'b1);
    check("live after acccd", 64'(match_live), 64'd1);
    check_result("acccd seq", 1'b1, 4, 1, 1'b0);
    accept("acccd seq");

    send_pkt("abxd", 0);
    check("live stays 0 abxd", 64'(match_live), 64'd0);
    check_result("abxd seq", 1'b0, 0, 0, 1'b0);
    accept("abxd seq");

    // Overwrite of an unaccepted result.
    send_pkt("adad", 0);
    check_result("adad held", 1'b1, 1, 2, 1'b0);
    send_pkt("zz", 0);
    check_result("zz overwrite", 1'b0, 0, 0, 1'b1);
    accept("zz overwrite");
    send_pkt("ad", 0);
    check_result("after ovf", 1'b1, 1, 1, 1'b0);
    accept("after ovf");

    // Acceptance and new capture on the same edge: new result wins, no ovf.
    send_pkt("ad", 0);
    result_ready = 1'b1;
    drive(4, 1'b1, 1'b1, 1'b1);
    result_ready = 1'b0;
    check_result("accept+capture", 1'b0, 0, 0, 1'b0);
    accept("accept+capture");

    // en gaps with garbage inputs between bytes.
    send_pkt("abd", 1);
    check_result("abd gapped", 1'b1, 2, 1, 1'b0);
    accept("abd gapped");

    // Asynchronous reset mid-packet with a pending result and a live match.
    send_pkt("ad", 0);
    drive(1, 1'b1, 1'b0, 1'b1);
    drive(4, 1'b0, 1'b0, 1'b1);
    drive(2, 1'b0, 1'b0, 1'b1);
    check("pre-reset valid/live", {result_valid, match_live}, 64'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {result_valid, result_match, result_offset, result_count, result_ovf, match_live}, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt("cd", 0);
    check_result("cd after reset", 1'b0, 0, 0, 1'b0);
    accept("cd after reset");
    send_pkt("ad", 0);
    check_result("ad after reset", 1'b1, 1, 1, 1'b0);
    accept("ad after reset");

    // Random packets against the reference model, consumer always ready.
    result_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int  q[$];
      int  len;
      bit  em;
      int  eo, ec;
      len = int'($urandom_range(1, 10));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 4)));
      ref_pkt(q, em, eo, ec);
      for (int i = 0; i < len; i++) begin
        drive(q[i], i == 0, i == len - 1, 1'b1);
        if (i < len - 1 && $urandom_range(0, 2) == 0) idle();
      end
      check("rand valid", 64'(result_valid), 64'd1);
      check("rand fields", {result_match, result_offset, result_count, result_ovf},
            {em, OW'(eo), CW'(ec), 1'b0});
      check("rand live", 64'(match_live), 64'(em));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
    end
    result_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
